// File: rtl/query_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// query_port_arbiter_pkg
// Shared definitions for the read-RAM query port arbiter: pipeline status
// encodings, field widths, the per-requester state type and the in-flight
// tag record {valid, id}.
// -----------------------------------------------------------------------------
package query_port_arbiter_pkg;

  localparam int READ_NUM_WIDTH = 8;
  localparam int QRY_DATA_W     = 8;
  localparam int STATUS_W       = 6;
  localparam int POS_W          = 7;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W       = 3;

  typedef enum logic [STATUS_W-1:0] {
    BUBBLE  = 6'b000000,
    F_init  = 6'b000001,
    F_run   = 6'b000010,
    F_break = 6'b000100,
    BCK_INI = 6'b001000,
    BCK_RUN = 6'b010000,
    BCK_END = 6'b100000
  } status_e;

  typedef enum logic {
    REQ_IDLE    = 1'b0,
    REQ_PENDING = 1'b1
  } req_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/query_port_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// query_port_arbiter_rr_grant
// Combinational round-robin picker. Scans the eligible mask starting at the
// pointer and returns the first hit as a one-hot grant plus its index.
// Ports:
//   eligible_i  requesters that may be granted this cycle
//   ptr_i       highest-priority requester index (0..NUM_REQ-1)
//   grant_o     one-hot grant, all zero when nothing is eligible
//   grant_id_o  index of the granted requester (0 when none)
//   any_o       some requester was granted
// -----------------------------------------------------------------------------
module query_port_arbiter_rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_id_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Wrap ptr+k back into range without a modulo operator.
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_o && eligible_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/query_port_arbiter.sv
// -----------------------------------------------------------------------------
// query_port_arbiter
// Shares the single read-RAM query port between NUM_REQ requesters. Grants
// round-robin, registers the winning fields onto the ram_* outputs, tracks the
// query in a tag shift register aligned to the RAM latency and steers the
// returned base code back to the requester that issued it.
//
// Handshake: a requester raises req_valid with its fields stable; req_ready is
// a same-cycle combinational accept (only when stall is low), and on that edge
// the query is issued. A requester owns at most one query in flight; the
// response is a one-cycle rsp_valid strobe that cannot be back-pressured.
//
// Ports:
//   clk, reset (async, active high), stall (freezes every register)
//   req_valid/req_ready, req_status/req_position/req_read_num (flattened)
//   ram_status/ram_position/ram_read_num -> RAM, ram_query_data <- RAM
//   rsp_valid (one-hot), rsp_id, rsp_data, busy (any query in flight)
// Optional: define QUERY_ARB_PERF_EN to add perf_accept_cnt (NUM_REQ*32) and
//   perf_conflict_cnt (32), saturating counters cleared by reset.
// -----------------------------------------------------------------------------
module query_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int READ_NUM_WIDTH = 8,
  parameter int RAM_LAT        = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*6-1:0]               req_status,
  input  logic [NUM_REQ*7-1:0]               req_position,
  input  logic [NUM_REQ*READ_NUM_WIDTH-1:0]  req_read_num,
  output logic [5:0]                         ram_status,
  output logic [6:0]                         ram_position,
  output logic [READ_NUM_WIDTH-1:0]          ram_read_num,
  input  logic [7:0]                         ram_query_data,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [ID_W-1:0]                    rsp_id,
  output logic [7:0]                         rsp_data,
  output logic                               busy
`ifdef QUERY_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]              perf_accept_cnt,
  output logic [31:0]                        perf_conflict_cnt
`endif
);

  import query_port_arbiter_pkg::*;

  // One extra stage: the RAM needs RAM_LAT cycles after ram_* is registered.
  localparam int TAG_STAGES = RAM_LAT + 1;

  req_state_e                state_q [NUM_REQ];
  req_state_e                state_d [NUM_REQ];
  tag_t                      tag_q   [TAG_STAGES];
  tag_t                      tag_in;
  tag_t                      tag_last;
  logic [ID_W-1:0]           ptr_q, ptr_d;
  status_e                   ram_status_q, ram_status_d;
  logic [6:0]                ram_position_q, ram_position_d;
  logic [READ_NUM_WIDTH-1:0] ram_read_num_q, ram_read_num_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
  logic [7:0]                rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        grant;
  logic [ID_W-1:0]           grant_id;
  logic                      grant_any;
  logic                      accept;
  logic                      rsp_fire;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (state_q[i] == REQ_IDLE);
    end
  end

  query_port_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .any_o      (grant_any)
  );

  // req_ready is combinational, so it is also forced low while reset is held.
  assign accept    = grant_any && !stall && !reset;
  assign req_ready = accept ? grant : '0;
  assign tag_last  = tag_q[TAG_STAGES-1];
  assign rsp_fire  = tag_last.valid && !stall;

  // Per-requester IDLE/PENDING state.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        REQ_IDLE:    if (accept && grant[i]) state_d[i] = REQ_PENDING;
        REQ_PENDING: if (rsp_fire && (int'(tag_last.id) == i)) state_d[i] = REQ_IDLE;
        default:     state_d[i] = REQ_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      busy = busy | (state_q[i] == REQ_PENDING);
    end
  end

  // Issue and response datapath.
  always_comb begin
    tag_in         = '0;
    tag_in.valid   = accept;
    tag_in.id      = TAG_ID_W'(grant_id);
    ptr_d          = ptr_q;
    ram_status_d   = BUBBLE;
    ram_position_d = ram_position_q;
    ram_read_num_d = ram_read_num_q;
    if (accept) begin
      ptr_d          = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      ram_status_d   = status_e'(req_status[int'(grant_id)*6 +: 6]);
      ram_position_d = req_position[int'(grant_id)*7 +: 7];
      ram_read_num_d = req_read_num[int'(grant_id)*READ_NUM_WIDTH +: READ_NUM_WIDTH];
    end
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = rsp_fire && (int'(tag_last.id) == i);
    end
    if (rsp_fire) begin
      rsp_id_d   = tag_last.id[ID_W-1:0];
      rsp_data_d = ram_query_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= REQ_IDLE;
      for (int s = 0; s < TAG_STAGES; s++) tag_q[s] <= '0;
      ptr_q          <= '0;
      ram_status_q   <= BUBBLE;
      ram_position_q <= '0;
      ram_read_num_q <= '0;
      rsp_valid_q    <= '0;
      rsp_id_q       <= '0;
      rsp_data_q     <= 8'hFF;
    end else if (!stall) begin
      for (int i = 0; i < NUM_REQ; i++) state_q[i] <= state_d[i];
      tag_q[0] <= tag_in;
      for (int s = 1; s < TAG_STAGES; s++) tag_q[s] <= tag_q[s-1];
      ptr_q          <= ptr_d;
      ram_status_q   <= ram_status_d;
      ram_position_q <= ram_position_d;
      ram_read_num_q <= ram_read_num_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign ram_status   = ram_status_q;
  assign ram_position = ram_position_q;
  assign ram_read_num = ram_read_num_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;

`ifdef QUERY_ARB_PERF_EN
  logic [31:0] accept_cnt_q [NUM_REQ];
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) accept_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && grant[i] && (accept_cnt_q[i] != '1)) accept_cnt_q[i] <= accept_cnt_q[i] + 1'b1;
      end
      if (($countones(eligible) >= 2) && (conflict_cnt_q != '1)) conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  always_comb begin
    perf_accept_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) perf_accept_cnt[i*32 +: 32] = accept_cnt_q[i];
  end

  assign perf_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_query_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_query_port_arbiter
// Drives the arbiter with directed and random request/stall patterns against a
// fixed-latency RAM model. The reference tracks each requester as busy/free,
// the round-robin position as an integer, and each accepted query as an
// expected response (due non-stalled edge, id, data looked up directly from
// the RAM contents). Compile with QUERY_ARB_PERF_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_query_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int RNW     = 8;
  localparam int RAM_LAT = 4;
  localparam int W       = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     stall;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*6-1:0]     req_status;
  logic [NUM_REQ*7-1:0]     req_position;
  logic [NUM_REQ*RNW-1:0]   req_read_num;
  logic [5:0]               ram_status;
  logic [6:0]               ram_position;
  logic [RNW-1:0]           ram_read_num;
  logic [7:0]               ram_query_data;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [7:0]               rsp_data;
  logic                     busy;
`ifdef QUERY_ARB_PERF_EN
  logic [NUM_REQ*32-1:0]    perf_accept_cnt;
  logic [31:0]              perf_conflict_cnt;
`endif

  query_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .READ_NUM_WIDTH(RNW), .RAM_LAT(RAM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_status(req_status), .req_position(req_position), .req_read_num(req_read_num),
    .ram_status(ram_status), .ram_position(ram_position), .ram_read_num(ram_read_num),
    .ram_query_data(ram_query_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef QUERY_ARB_PERF_EN
    , .perf_accept_cnt(perf_accept_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model: lookup, RAM_LAT stall-aware stages ----------------
  logic [7:0] ram_mem  [0:127];
  logic [7:0] ram_pipe [RAM_LAT];

  always @(posedge clk) begin
    if (!stall) begin
      ram_pipe[0] <= ram_mem[ram_position ^ ram_read_num[6:0]];
      for (int k = 1; k < RAM_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
  end
  assign ram_query_data = ram_pipe[RAM_LAT-1];

  // ---------------- stimulus fields ----------------
  logic [5:0]     st  [NUM_REQ];
  logic [6:0]     pos [NUM_REQ];
  logic [RNW-1:0] rn  [NUM_REQ];

  // ---------------- reference model ----------------
  bit             pend [NUM_REQ];
  int             ptr;
  int             e_cnt;
  logic [W-1:0]   exp_q[$];
  logic [5:0]     exp_ram_status;
  logic [6:0]     exp_ram_pos;
  logic [RNW-1:0] exp_ram_rn;
  logic [ID_W-1:0] exp_rid;
  logic [7:0]     exp_rdata;
  logic [NUM_REQ-1:0] obs_ready;
  logic [NUM_REQ-1:0] obs_rsp;
`ifdef QUERY_ARB_PERF_EN
  int             conf_cnt;
  int             acc_cnt [NUM_REQ];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    ptr = 0;
    exp_q.delete();
    exp_ram_status = 6'b000000;
    exp_ram_pos    = '0;
    exp_ram_rn     = '0;
    exp_rid        = '0;
    exp_rdata      = 8'hFF;
`ifdef QUERY_ARB_PERF_EN
    conf_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;
`endif
  endtask

  function automatic int model_grant();
    int i;
    if (stall || reset) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      i = (ptr + k) % NUM_REQ;
      if (req_valid[i] && !pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      st[i]  = 6'(1 << $urandom_range(0, 5));
      pos[i] = 7'($urandom_range(0, 127));
      rn[i]  = RNW'($urandom);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_status[i*6 +: 6]       = st[i];
      req_position[i*7 +: 7]     = pos[i];
      req_read_num[i*RNW +: RNW] = rn[i];
    end
  endtask

  // Called at a negedge with inputs set; checks, steps one clock, returns at next negedge.
  task automatic run_cycle();
    int g;
    int n_elig;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rv;
    logic [W-1:0] item;
    drive();
    #1;
    g = model_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;
    obs_rsp   = rsp_valid;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("ram_status", 32'(ram_status), 32'(exp_ram_status));
    check("ram_position", 32'(ram_position), 32'(exp_ram_pos));
    check("ram_read_num", 32'(ram_read_num), 32'(exp_ram_rn));
    n_elig = 0;
    for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && !pend[i]) n_elig++;
    begin
      bit any_pend = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) any_pend |= pend[i];
      check("busy", 32'(busy), 32'(any_pend));
    end
    while (exp_q.size() > 0 && int'(exp_q[0][31:16]) < e_cnt) void'(exp_q.pop_front());
    exp_rv = '0;
    if (exp_q.size() > 0 && int'(exp_q[0][31:16]) == e_cnt) begin
      item = exp_q[0];
      exp_rv[item[9:8]] = 1'b1;
      exp_rid   = item[ID_W+7:8];
      exp_rdata = item[7:0];
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("rsp_id", 32'(rsp_id), 32'(exp_rid));
    check("rsp_data", 32'(rsp_data), 32'(exp_rdata));
    @(posedge clk);
    if (!stall && !reset) begin
      e_cnt++;
`ifdef QUERY_ARB_PERF_EN
      if (n_elig >= 2) conf_cnt++;
      if (g >= 0) acc_cnt[g]++;
`endif
      if (g >= 0) begin
        pend[g] = 1'b1;
        exp_q.push_back({16'(e_cnt + RAM_LAT + 1), 8'(g), ram_mem[pos[g] ^ rn[g][6:0]]});
        ptr = (g + 1) % NUM_REQ;
        exp_ram_status = st[g];
        exp_ram_pos    = pos[g];
        exp_ram_rn     = rn[g];
      end else begin
        exp_ram_status = 6'b000000;
      end
      foreach (exp_q[j]) if (int'(exp_q[j][31:16]) == e_cnt) pend[exp_q[j][9:8]] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    req_valid = '0;
    for (int c = 0; c < n; c++) run_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    for (int i = 0; i < 128; i++) ram_mem[i] = 8'($urandom);
    ram_mem[37 ^ 5] = 8'h02;
    reset = 1'b1; stall = 1'b0; req_valid = '0;
    rand_fields(); drive();
    e_cnt = 0;
    model_reset();

    @(negedge clk); @(negedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ram_status", 32'(ram_status), 32'h0);
    check("rst_ram_position", 32'(ram_position), 32'h0);
    check("rst_ram_read_num", 32'(ram_read_num), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'hFF);
    reset = 1'b0;
    @(negedge clk);

    // Single request from requester 1: F_run, position 37, read_num 5.
    st[1] = 6'b000010; pos[1] = 7'd37; rn[1] = 8'd5;
    req_valid = 4'b0010;
    run_cycle();
    check("single_ready", 32'(obs_ready), 32'h2);
    req_valid = '0;
    run_cycle();
    check("single_ram_pos", 32'(ram_position), 32'd37);
    for (int c = 0; c < RAM_LAT; c++) begin
      run_cycle();
      check("single_no_early_rsp", 32'(obs_rsp), 32'h0);
    end
    run_cycle();
    check("single_rsp_strobe", 32'(obs_rsp), 32'h2);
    check("single_rsp_data", 32'(rsp_data), 32'h02);
    idle_cycles(4);

    // All four requesters valid continuously.
    req_valid = 4'hF;
    for (int c = 0; c < 40; c++) begin
      rand_fields();
      run_cycle();
    end
    idle_cycles(10);

    // Two queries in flight, then stall for 3 cycles.
    rand_fields();
    req_valid = 4'b0101;
    run_cycle(); run_cycle();
    req_valid = '0;
    run_cycle();
    stall = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) run_cycle();
    stall = 1'b0;
    idle_cycles(10);

    // Requester 2 re-requests in the cycle after its response strobe.
    rand_fields();
    req_valid = 4'b0100;
    run_cycle();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      run_cycle();
      if (obs_rsp[2]) seen = 1'b1;
    end
    check("rereq_rsp_seen", 32'(seen), 32'h1);
    req_valid = 4'b0100;
    run_cycle();
    check("rereq_ready", 32'(obs_ready[2]), 32'h1);
    idle_cycles(10);

    // Requesters 0 and 3 both requesting for 10 cycles.
    req_valid = 4'b1001;
    for (int c = 0; c < 10; c++) begin
      rand_fields();
      run_cycle();
    end
    idle_cycles(8);

    // Random traffic with random stalls.
    for (int c = 0; c < 600; c++) begin
      rand_fields();
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ($urandom_range(0, 99) < 60);
      stall = ($urandom_range(0, 99) < 15);
      run_cycle();
    end
    stall = 1'b0;

`ifdef QUERY_ARB_PERF_EN
    check("perf_conflict", perf_conflict_cnt, 32'(conf_cnt));
    for (int i = 0; i < NUM_REQ; i++) check("perf_accept", perf_accept_cnt[i*32 +: 32], 32'(acc_cnt[i]));
`endif

    // Asynchronous reset with several queries in flight.
    req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      rand_fields();
      run_cycle();
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_ram_status", 32'(ram_status), 32'h0);
    check("arst_req_ready", 32'(req_ready), 32'h0);
    check("arst_rsp_data", 32'(rsp_data), 32'hFF);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    for (int c = 0; c < RAM_LAT + 4; c++) begin
      run_cycle();
      check("arst_no_stale_rsp", 32'(obs_rsp), 32'h0);
    end
    rand_fields();
    req_valid = 4'b1000;
    run_cycle();
    check("post_rst_ready", 32'(obs_ready), 32'h8);
    idle_cycles(RAM_LAT + 4);
    for (int c = 0; c < 100; c++) begin
      rand_fields();
      for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ($urandom_range(0, 99) < 50);
      stall = ($urandom_range(0, 99) < 10);
      run_cycle();
    end
    stall = 1'b0;
    idle_cycles(10);

`ifdef QUERY_ARB_PERF_EN
    check("perf_conflict_end", perf_conflict_cnt, 32'(conf_cnt));
    for (int i = 0; i < NUM_REQ; i++) check("perf_accept_end", perf_accept_cnt[i*32 +: 32], 32'(acc_cnt[i]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
